// File: rtl/ser_pkg.sv
// Shared state and parity-type encodings for the PISO serializer.
// The PARITY state is only reachable when SER_PARITY_EN is defined.
package ser_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } ser_state_t;

    localparam logic EVEN = 1'b0;
    localparam logic ODD  = 1'b1;

endpackage

// File: rtl/ser_parity_calc.sv
// Parity of a parallel word; i_par_typ selects even (EVEN) or odd (ODD).
// Only instantiated when SER_PARITY_EN is defined.
module ser_parity_calc
    import ser_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_par_typ,
    output logic                  o_parity
);

    assign o_parity = (^i_data) ^ (i_par_typ == ODD);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer, LSB- or MSB-first, one bit per tick.
// Optional trailing parity bit when SER_PARITY_EN is defined.
module piso_serializer
    import ser_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter bit MSB_FIRST  = 1'b0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  i_data_valid,
    input  logic                  i_shift_enable,
`ifdef SER_PARITY_EN
    input  logic                  PAR_TYP,
`endif
    output logic                  o_data,
    output logic                  o_busy,
    output logic                  o_ser_done
);

    localparam int             CW   = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(DATA_WIDTH - 1);

    ser_state_t            r_state;
    ser_state_t            w_next;
    logic [DATA_WIDTH-1:0] r_buf;
    logic [CW-1:0]         r_cnt;
    logic                  r_done;
    logic                  w_load;
    logic                  w_adv;
    logic                  w_end;
    logic                  w_ser_bit;

    assign w_ser_bit  = MSB_FIRST ? r_buf[DATA_WIDTH-1] : r_buf[0];
    assign o_busy     = (r_state != IDLE);
    assign o_ser_done = r_done;

`ifdef SER_PARITY_EN
    logic r_par;
    logic w_par_in;

    ser_parity_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_par (
        .i_data    (P_DATA),
        .i_par_typ (PAR_TYP),
        .o_parity  (w_par_in)
    );

    // Parity is frozen at load so later P_DATA changes cannot leak in.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_par <= 1'b0;
        end else if (w_load) begin
            r_par <= w_par_in;
        end
    end
`endif

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_adv  = 1'b0;
        w_end  = 1'b0;
        o_data = 1'b1;
        unique case (r_state)
            IDLE: begin
                if (i_data_valid) begin
                    w_load = 1'b1;
                    w_next = SHIFT;
                end
            end
            SHIFT: begin
                o_data = w_ser_bit;
                if (i_shift_enable) begin
                    if (r_cnt == LAST) begin
`ifdef SER_PARITY_EN
                        w_next = PARITY;
`else
                        w_next = IDLE;
                        w_end  = 1'b1;
`endif
                    end else begin
                        w_adv = 1'b1;
                    end
                end
            end
`ifdef SER_PARITY_EN
            PARITY: begin
                o_data = r_par;
                if (i_shift_enable) begin
                    w_next = IDLE;
                    w_end  = 1'b1;
                end
            end
`endif
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= IDLE;
            r_buf   <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= w_end;
            if (w_load) begin
                r_buf <= P_DATA;
                r_cnt <= '0;
            end else if (w_adv) begin
                r_buf <= MSB_FIRST ? {r_buf[DATA_WIDTH-2:0], 1'b0}
                                   : {1'b0, r_buf[DATA_WIDTH-1:1]};
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: LSB-first and MSB-first instances side by side.
// Build with SER_PARITY_EN defined to cover the parity bit.
module tb_piso_serializer;

`ifdef SER_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] P_DATA = 8'h00;
    logic       i_data_valid = 1'b0;
    logic       i_shift_enable = 1'b0;
`ifdef SER_PARITY_EN
    logic       PAR_TYP = 1'b0;
`endif
    logic       o_data, o_busy, o_ser_done;
    logic       o_data_m, o_busy_m, o_ser_done_m;

    int  n_pass = 0;
    int  n_total = 0;
    bit  sb_en = 1'b1;
    logic q_l[$];
    logic q_m[$];

    always #5 CLK = ~CLK;

    piso_serializer #(.DATA_WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .CLK            (CLK),
        .RST            (RST),
        .P_DATA         (P_DATA),
        .i_data_valid   (i_data_valid),
        .i_shift_enable (i_shift_enable),
`ifdef SER_PARITY_EN
        .PAR_TYP        (PAR_TYP),
`endif
        .o_data         (o_data),
        .o_busy         (o_busy),
        .o_ser_done     (o_ser_done)
    );

    piso_serializer #(.DATA_WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .CLK            (CLK),
        .RST            (RST),
        .P_DATA         (P_DATA),
        .i_data_valid   (i_data_valid),
        .i_shift_enable (i_shift_enable),
`ifdef SER_PARITY_EN
        .PAR_TYP        (PAR_TYP),
`endif
        .o_data         (o_data_m),
        .o_busy         (o_busy_m),
        .o_ser_done     (o_ser_done_m)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t",
                      name, act, exp, $time);
    endtask

    // Scoreboard: every bit closed by a tick must match the queued expectation.
    always @(negedge CLK) begin
        if (sb_en && RST && i_shift_enable) begin
            if (o_busy) begin
                if (q_l.size() == 0) chk("sb_underflow_l", 1, 0);
                else chk("bit_lsb", 32'(o_data), 32'(q_l.pop_front()));
            end
            if (o_busy_m) begin
                if (q_m.size() == 0) chk("sb_underflow_m", 1, 0);
                else chk("bit_msb", 32'(o_data_m), 32'(q_m.pop_front()));
            end
        end
    end

    // Called at posedge+1 with the DUT idle; returns in the done cycle.
    task automatic run_word(input logic [7:0] d, input int sp,
                            input logic [7:0] el, input logic [7:0] em,
                            input logic ep, input logic pt,
                            input logic [7:0] after_d, input logic after_v,
                            input int inj);
        int  cyc;
        bit  seen;
        for (int i = 7; i >= 0; i--) begin
            q_l.push_back(el[i]);
            q_m.push_back(em[i]);
        end
`ifdef SER_PARITY_EN
        q_l.push_back(pt ? ~ep : ep);
        q_m.push_back(pt ? ~ep : ep);
        PAR_TYP = pt;
`endif
        P_DATA = d;
        i_data_valid = 1'b1;
        @(posedge CLK); #1;
        P_DATA = after_d;
        i_data_valid = after_v;
        @(negedge CLK);
        chk("load_busy_l", 32'(o_busy), 1);
        chk("load_busy_m", 32'(o_busy_m), 1);
        chk("first_bit_l", 32'(o_data), 32'(el[7]));
        chk("first_bit_m", 32'(o_data_m), 32'(em[7]));
        chk("done_low", 32'(o_ser_done), 0);
        @(posedge CLK); #1;
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < NB * sp + 20) begin
            i_shift_enable = ((cyc % sp) == sp - 1);
            if (inj >= 0) begin
                i_data_valid = (cyc == inj);
                P_DATA = (cyc == inj) ? 8'hFF : after_d;
            end
            @(posedge CLK); #1;
            cyc++;
            if (o_ser_done) seen = 1'b1;
        end
        i_shift_enable = 1'b0;
        if (inj >= 0) i_data_valid = 1'b0;
        chk("done_seen", 32'(seen), 1);
        chk("ticks_to_done", 32'(cyc), 32'(NB * sp));
        chk("done_m", 32'(o_ser_done_m), 1);
        chk("done_busy_l", 32'(o_busy), 0);
        chk("done_busy_m", 32'(o_busy_m), 0);
        chk("done_idle_data", 32'(o_data), 1);
    endtask

    typedef struct {
        logic [7:0] d;
        int         sp;
        logic [7:0] el;
        logic [7:0] em;
        logic       ep;
    } vec_t;

    vec_t tbl[4];

    initial begin
        // Expected sequences listed first-bit-out at the left.
        tbl[0] = '{8'hA5, 4, 8'b10100101, 8'b10100101, 1'b0};
        tbl[1] = '{8'h80, 2, 8'b00000001, 8'b10000000, 1'b1};
        tbl[2] = '{8'h3C, 3, 8'b00111100, 8'b00111100, 1'b0};
        tbl[3] = '{8'h0F, 1, 8'b11110000, 8'b00001111, 1'b0};

        repeat (3) @(posedge CLK);
        #1;
        chk("rst_data_l", 32'(o_data), 1);
        chk("rst_data_m", 32'(o_data_m), 1);
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_done", 32'(o_ser_done), 0);
        RST = 1'b1;
        @(posedge CLK); #1;

        i_shift_enable = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        i_shift_enable = 1'b0;
        chk("idle_tick_busy", 32'(o_busy), 0);
        chk("idle_tick_data", 32'(o_data), 1);

        for (int k = 0; k < 4; k++) begin
            run_word(tbl[k].d, tbl[k].sp, tbl[k].el, tbl[k].em, tbl[k].ep,
                     1'b0, ~tbl[k].d, 1'b0, -1);
            repeat (2) @(posedge CLK);
            #1;
        end

        // Back-to-back with i_data_valid held high across the first word.
        run_word(8'h0F, 2, 8'b11110000, 8'b00001111, 1'b0, 1'b0,
                 8'hF0, 1'b1, -1);
        run_word(8'hF0, 2, 8'b00001111, 8'b11110000, 1'b0, 1'b0,
                 8'h00, 1'b0, -1);
        @(posedge CLK); #1;
        chk("b2b_done_one_cycle", 32'(o_ser_done), 0);
        @(posedge CLK); #1;

        // Load request during the third bit must be ignored.
        run_word(8'h00, 4, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 9);
        @(posedge CLK); #1;
        chk("busy_inj_idle", 32'(o_busy), 0);

`ifdef SER_PARITY_EN
        run_word(8'h07, 2, 8'b11100000, 8'b00000111, 1'b1, 1'b0,
                 8'h00, 1'b0, -1);
        @(posedge CLK); #1;
        run_word(8'h07, 2, 8'b11100000, 8'b00000111, 1'b1, 1'b1,
                 8'h00, 1'b0, -1);
        @(posedge CLK); #1;
`endif

        // Asynchronous reset in the middle of bit 5.
        sb_en = 1'b0;
        P_DATA = 8'h00;
        i_data_valid = 1'b1;
        @(posedge CLK); #1;
        i_data_valid = 1'b0;
        i_shift_enable = 1'b1;
        repeat (4) @(posedge CLK);
        #1;
        i_shift_enable = 1'b0;
        chk("pre_rst_busy", 32'(o_busy), 1);
        chk("pre_rst_data", 32'(o_data), 0);
        RST = 1'b0;
        #1;
        chk("rst_mid_data_l", 32'(o_data), 1);
        chk("rst_mid_data_m", 32'(o_data_m), 1);
        chk("rst_mid_busy", 32'(o_busy), 0);
        chk("rst_mid_done", 32'(o_ser_done), 0);
        #3;
        RST = 1'b1;
        sb_en = 1'b1;
        @(posedge CLK); #1;
        run_word(8'h3C, 2, 8'b00111100, 8'b00111100, 1'b0, 1'b0,
                 8'hFF, 1'b0, -1);
        @(posedge CLK); #1;

        chk("sb_drained_l", 32'(q_l.size()), 0);
        chk("sb_drained_m", 32'(q_m.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the parallel word width (legal range 2..32).
REQ-002 The block SHALL have parameter MSB_FIRST, default 0: 0 shifts out LSB first, 1 shifts out MSB first.
REQ-003 Port CLK, input, 1: the single clock; all state changes on its rising edge.
REQ-004 Port RST, input, 1: asynchronous, active-low reset.
REQ-005 Port P_DATA, input, DATA_WIDTH: parallel word to serialise.
REQ-006 Port i_data_valid, input, 1: request to load P_DATA.
REQ-007 Port i_shift_enable, input, 1: bit-period tick; one bit advances per asserted cycle.
REQ-008 Port o_data, output, 1: serial bit.
REQ-009 Port o_busy, output, 1: high while a word (and its parity bit, if compiled in) is in flight.
REQ-010 Port o_ser_done, output, 1: single-cycle pulse on the final bit's closing tick.

Function
REQ-011 The block SHALL implement states IDLE, SHIFT and, with parity compiled in, PARITY.
REQ-012 In IDLE, o_data SHALL be 1, o_busy 0 and o_ser_done 0.
REQ-013 Load: on an edge with state IDLE and i_data_valid=1, the block SHALL capture P_DATA into the shift buffer, clear the bit counter and enter SHIFT.
REQ-014 The first data bit SHALL appear on o_data in the cycle after the load edge (latency 1); o_busy SHALL rise in the same cycle.
REQ-015 In SHIFT, o_data SHALL be buffer[0] when MSB_FIRST=0 and buffer[DATA_WIDTH-1] when MSB_FIRST=1.
REQ-016 On each SHIFT edge with i_shift_enable=1 and counter<DATA_WIDTH-1, the buffer SHALL shift one position toward the output bit and the counter SHALL increment.
REQ-017 On a SHIFT edge with i_shift_enable=1 and counter=DATA_WIDTH-1, the block SHALL leave SHIFT (to PARITY if compiled in, otherwise to IDLE).
REQ-018 The counter SHALL be $clog2(DATA_WIDTH) bits wide and SHALL never wrap inside a word.
REQ-019 o_ser_done SHALL be 1 for exactly the one cycle after the edge that leaves the last serial state; o_busy SHALL be 0 from that same cycle.
REQ-020 Each bit SHALL hold on o_data until the next i_shift_enable edge, so bit duration is fully defined by the tick spacing.
REQ-021 i_data_valid while o_busy=1 SHALL be ignored, with no capture and no change to the word in flight.
REQ-022 i_data_valid in the o_ser_done cycle SHALL be accepted because the state is IDLE, giving back-to-back words with no idle tick.
REQ-023 i_shift_enable in IDLE SHALL have no effect.
REQ-024 P_DATA changes after the load edge SHALL NOT affect the word in flight.

Reset
REQ-025 Asserting RST low SHALL immediately force state IDLE, buffer 0, counter 0, o_data 1, o_busy 0 and o_ser_done 0, including during SHIFT or PARITY.
REQ-026 After RST deasserts, the first accepted load SHALL behave exactly as in REQ-013.

Configuration
REQ-027 Macro SER_PARITY_EN SHALL control the parity feature.
REQ-028 With SER_PARITY_EN defined:
- input port PAR_TYP (1 bit) SHALL exist: 0 = even, 1 = odd;
- parity of P_DATA SHALL be computed and registered at the load edge;
- the PARITY state SHALL drive that bit for one tick after the last data bit.
REQ-029 Without SER_PARITY_EN, PAR_TYP and the PARITY state SHALL be absent, and SHIFT SHALL go directly to IDLE.

Structure
REQ-030 Package ser_pkg SHALL hold:
- the state encoding constants (IDLE, SHIFT, PARITY);
- the parity type constants (EVEN=0, ODD=1).
REQ-031 Parity SHALL be computed in sub-module ser_parity_calc, parameterised by DATA_WIDTH and instantiated only under SER_PARITY_EN.

Verification
REQ-032 Order: DATA_WIDTH=8, MSB_FIRST=0, P_DATA=0xA5, tick every 4 cycles -> o_data sequence 1,0,1,0,0,1,0,1; o_ser_done pulses once after 8 ticks.
REQ-033 Order: MSB_FIRST=1, P_DATA=0xA5 -> sequence 1,0,1,0,0,1,0,1 (MSB first), and 0x80 -> 1,0,0,0,0,0,0,0.
REQ-034 Back-to-back: load 0x0F, hold i_data_valid high with P_DATA=0xF0 -> second word starts in the o_ser_done cycle, 16 consecutive bit periods, no idle gap.
REQ-035 Busy: i_data_valid pulse with 0xFF during the 3rd bit of 0x00 -> ignored; output stays all zeros; one o_ser_done.
REQ-036 Parity: SER_PARITY_EN, PAR_TYP=0, P_DATA=0x07 -> parity bit 1; PAR_TYP=1 -> parity bit 0; o_ser_done after 9 ticks.
REQ-037 Reset: RST low during bit 5 -> o_data=1 and o_busy=0 immediately; a new load of 0x3C afterwards serialises correctly from bit 0.
